// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam logic IDLE_LEVEL_DEF = 1'b0;

    // Bit index width; kept at least 1 so the counter is never zero-width.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage with valid/ready intake, framing strobes
// and a fixed inter-word idle gap.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int              IW       = cnt_w(WIDTH);
    localparam logic [IW-1:0]   IDX_LAST = IW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       gap_q, gap_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             ser_first_q, ser_first_d;
    logic             ser_last_q, ser_last_d;
    logic             at_last;
    logic             take;

    assign at_last  = (state_q == SHIFT) && (idx_q == IDX_LAST);
    assign in_ready = (state_q == IDLE) || (at_last && (GAP_CYCLES == 0));
    assign take     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = SHIFT;
                    sr_d    = in_data;
                    idx_d   = '0;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    if (take) begin
                        sr_d  = in_data;
                        idx_d = '0;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end else begin
                    sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
                    idx_d = idx_q + IW'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so a word's first bit
        // appears in the cycle right after the accepting edge.
        ser_valid_d = (state_d == SHIFT);
        ser_out_d   = ser_valid_d ? (MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0]) : IDLE_LEVEL;
        ser_first_d = ser_valid_d && (idx_d == '0);
        ser_last_d  = ser_valid_d && (idx_d == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: three serializer configurations (MSB/gap0, MSB/gap2, LSB/gap0).
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din [3];
    logic       vin [3];
    logic       rdy [3];
    logic       so  [3];
    logic       sv  [3];
    logic       sf  [3];
    logic       sl  [3];
    logic       bsy [3];

    int checks = 0;
    int errors = 0;

    // Expected entries: {bit, first, last}
    logic [2:0] sb0[$];
    logic [2:0] sb1[$];
    logic [2:0] sb2[$];

    int run_len = 0;
    int max_run = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .ser_first(sf[0]), .ser_last(sl[0]), .busy(bsy[0]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_m2 (
        .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .ser_first(sf[1]), .ser_last(sl[1]), .busy(bsy[1]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vin[2]), .in_ready(rdy[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .ser_first(sf[2]), .ser_last(sl[2]), .busy(bsy[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_word(input int k, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] e;
            e[2] = (k == 2) ? d[i] : d[7-i];
            e[1] = (i == 0);
            e[0] = (i == 7);
            case (k)
                0: sb0.push_back(e);
                1: sb1.push_back(e);
                default: sb2.push_back(e);
            endcase
        end
    endtask

    // Present a word and return how many cycles it waited for in_ready.
    task automatic send(input int k, input logic [7:0] d, input bit hold, output int waited);
        din[k] = d;
        vin[k] = 1'b1;
        waited = 0;
        while (!rdy[k] && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!rdy[k]) begin
            chk("ready_timeout", 32'(waited), 32'd0);
        end else begin
            @(posedge clk);
            push_word(k, d);
            #1;
        end
        if (!hold) vin[k] = 1'b0;
    endtask

    task automatic mon(input int k, input string nm);
        logic [2:0] e;
        if (!rst_n) return;
        if (sv[k]) begin
            case (k)
                0: e = (sb0.size() > 0) ? sb0.pop_front() : 3'bxxx;
                1: e = (sb1.size() > 0) ? sb1.pop_front() : 3'bxxx;
                default: e = (sb2.size() > 0) ? sb2.pop_front() : 3'bxxx;
            endcase
            chk({nm, "_bit"}, {31'd0, so[k]}, {31'd0, e[2]});
            chk({nm, "_first"}, {31'd0, sf[k]}, {31'd0, e[1]});
            chk({nm, "_last"}, {31'd0, sl[k]}, {31'd0, e[0]});
        end else begin
            chk({nm, "_idle_lvl"}, {31'd0, so[k]}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, "m0");
        mon(1, "m2");
        mon(2, "l0");
        if (rst_n && sv[0]) run_len = run_len + 1;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
    end

    initial begin
        int w;
        for (int k = 0; k < 3; k++) begin
            din[k] = 8'h00;
            vin[k] = 1'b0;
        end
        #1;
        chk("rst_out", {31'd0, so[0]}, 32'd0);
        chk("rst_valid", {31'd0, sv[0]}, 32'd0);
        chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
        chk("rst_ready", {31'd0, rdy[0]}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word from idle, accepted without wait
        send(0, 8'h1B, 1'b0, w);
        chk("single_wait", 32'(w), 32'd0);
        repeat (10) @(negedge clk);
        chk("single_busy", {31'd0, bsy[0]}, 32'd0);
        chk("single_drain", 32'(sb0.size()), 32'd0);

        // Back-to-back with in_valid held: no hole on the line
        max_run = 0;
        send(0, 8'hDB, 1'b1, w);
        send(0, 8'h6C, 1'b0, w);
        chk("b2b_wait", 32'(w), 32'd7);
        repeat (10) @(negedge clk);
        chk("b2b_run", 32'(max_run), 32'd16);

        // Backpressure at GAP_CYCLES=0: ready only at the last bit
        send(0, 8'h3C, 1'b0, w);
        send(0, 8'hC3, 1'b0, w);
        chk("bp0_wait", 32'(w), 32'd7);

        // GAP_CYCLES=2: 8 bits + 2 gap cycles of backpressure
        send(1, 8'h1B, 1'b0, w);
        send(1, 8'hA5, 1'b0, w);
        chk("gap_wait", 32'(w), 32'd10);
        repeat (4) @(negedge clk);
        chk("gap_busy_mid", {31'd0, bsy[1]}, 32'd1);

        // LSB-first
        send(2, 8'h1B, 1'b0, w);
        chk("lsb_wait", 32'(w), 32'd0);
        repeat (12) @(negedge clk);
        chk("drain_m0", 32'(sb0.size()), 32'd0);
        chk("drain_m2", 32'(sb1.size()), 32'd0);
        chk("drain_l0", 32'(sb2.size()), 32'd0);

        // Reset mid-word at bit 3 of 8'hFF
        send(0, 8'hFF, 1'b0, w);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", {31'd0, so[0]}, 32'd0);
        chk("arst_valid", {31'd0, sv[0]}, 32'd0);
        chk("arst_first", {31'd0, sf[0]}, 32'd0);
        chk("arst_last", {31'd0, sl[0]}, 32'd0);
        chk("arst_busy", {31'd0, bsy[0]}, 32'd0);
        chk("arst_ready", {31'd0, rdy[0]}, 32'd1);
        sb0.delete();
        vin[0] = 1'b1;
        din[0] = 8'h77;
        @(posedge clk);
        #1;
        chk("arst_no_take", {31'd0, bsy[0]}, 32'd0);
        vin[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h81, 1'b0, w);
        chk("post_rst_wait", 32'(w), 32'd0);
        repeat (12) @(negedge clk);
        chk("post_rst_drain", 32'(sb0.size()), 32'd0);
        chk("post_rst_busy", {31'd0, bsy[0]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
